binary_to_bcd_seq: RTL and testbench

- Sequential, multi-cycle binary-to-BCD converter. Uses the shift-and-add-3 (double-dabble) method, one iteration per clock.
- Replaces the combinational converter wherever timing or area matters. Sits between a binary producer (counter, ALU result) and display/formatting logic.
- Control is a start/busy/done handshake. The result register holds its value between conversions.

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_add3_digit.sv | 14 +
 rtl/binary_to_bcd_seq.sv | 99 +++++++++
 tb/tb_binary_to_bcd_seq.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types, constants and sizing helper for the BCD converter
package bcd_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Decimal digits needed to show 2^width-1: ceil(width*log10(2)).
    // 2^width is never a power of ten, so the ceiling is exact.
    function automatic int min_bcd_digits(input int width);
        return (width * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// rtl/bcd_add3_digit.sv - double-dabble per-digit correction (add 3 when digit >= 5)
module bcd_add3_digit
    import bcd_pkg::*;
(
    input  logic [NIBBLE_W-1:0] digit_i,
    output logic [NIBBLE_W-1:0] digit_o
);

    // Digit is at most 9 here, so the +3 never carries out of the nibble
    always_comb begin
        digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;
    end

endmodule

// File: rtl/binary_to_bcd_seq.sv
// rtl/binary_to_bcd_seq.sv - multi-cycle shift-and-add-3 binary to BCD converter
module binary_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [WIDTH-1:0]             binary,
    output logic                         busy,
    output logic                         done,
    output logic [NIBBLE_W*DIGITS-1:0]   bcd
);

    localparam int ACC_W = NIBBLE_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    if (WIDTH < 1) begin : g_bad_width
        $error("binary_to_bcd_seq: WIDTH must be >= 1");
    end
    if (DIGITS < min_bcd_digits(WIDTH)) begin : g_bad_digits
        $error("binary_to_bcd_seq: DIGITS too small for WIDTH");
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   bin_q, bin_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   bcd_q, bcd_d;

    logic [ACC_W-1:0]       acc_corr;
    logic [ACC_W+WIDTH-1:0] shifted;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_add3_digit u_add3 (
            .digit_i (acc_q[g*NIBBLE_W +: NIBBLE_W]),
            .digit_o (acc_corr[g*NIBBLE_W +: NIBBLE_W])
        );
    end

    // One double-dabble iteration: corrected accumulator and binary shift left together
    always_comb begin
        shifted = {acc_corr, bin_q} << 1;
    end

    // Next-state and datapath load/iterate decisions
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                    bin_d   = binary;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(WIDTH);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                {acc_d, bin_d} = shifted;
                cnt_d          = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                    bcd_d   = shifted[ACC_W+WIDTH-1:WIDTH];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
        end
    end

    assign busy = (state_q == ST_SHIFT);
    assign done = (state_q == ST_DONE);
    assign bcd  = bcd_q;

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// tb/tb_binary_to_bcd_seq.sv - directed self-checking bench for binary_to_bcd_seq
module tb_binary_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  binary;
    logic        busy, done;
    logic [11:0] bcd;

    logic        b_start;
    logic [9:0]  b_binary;
    logic        b_busy, b_done;
    logic [15:0] b_bcd;

    logic        c_start;
    logic [0:0]  c_binary;
    logic        c_busy, c_done;
    logic [3:0]  c_bcd;

    int errors = 0;
    int checks = 0;
    logic [11:0] prev_bcd;

    always #5 clk = ~clk;

    binary_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut (
        .clk(clk), .rst(rst), .start(start), .binary(binary),
        .busy(busy), .done(done), .bcd(bcd)
    );

    binary_to_bcd_seq #(.WIDTH(10), .DIGITS(4)) u_dut_w10 (
        .clk(clk), .rst(rst), .start(b_start), .binary(b_binary),
        .busy(b_busy), .done(b_done), .bcd(b_bcd)
    );

    binary_to_bcd_seq #(.WIDTH(1), .DIGITS(1)) u_dut_w1 (
        .clk(clk), .rst(rst), .start(c_start), .binary(c_binary),
        .busy(c_busy), .done(c_done), .bcd(c_bcd)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Start a conversion from IDLE and check latency, busy length, result and hold
    task automatic run_conv(input logic [7:0] val, input logic [11:0] exp);
        int n;
        int busy_cnt;
        @(negedge clk);
        start  = 1'b1;
        binary = val;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        binary = ~val;
        n = 0;
        busy_cnt = 0;
        check("bcd_hold_start", 32'(bcd), 32'(prev_bcd));
        while (!done && n < 20) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check("latency", n, 8);
        check("busy_len", busy_cnt, 8);
        check("result", 32'(bcd), 32'(exp));
        @(negedge clk);
        check("done_pulse", 32'(done), 0);
        check("bcd_hold_idle", 32'(bcd), 32'(exp));
        prev_bcd = exp;
    endtask

    initial begin
        int n;
        int m;
        int pulses;

        rst = 1'b1; start = 1'b1; binary = 8'd99;
        b_start = 1'b0; b_binary = '0; c_start = 1'b0; c_binary = '0;
        prev_bcd = '0;

        // Reset dominates start
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_busy", 32'(busy), 0);
            check("rst_done", 32'(done), 0);
            check("rst_bcd", 32'(bcd), 0);
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 0);

        run_conv(8'd0,   12'h000);
        run_conv(8'd10,  12'h010);
        run_conv(8'd42,  12'h042);
        run_conv(8'd99,  12'h099);
        run_conv(8'd153, 12'h153);
        run_conv(8'd255, 12'h255);

        // start and binary changes during busy are ignored
        @(negedge clk);
        start = 1'b1; binary = 8'd153;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 0; pulses = 0;
        while (n < 20) begin
            if (n == 2) begin start = 1'b1; binary = 8'd255; end
            else if (n == 3) start = 1'b0;
            if (done) begin
                pulses++;
                if (pulses == 1) begin
                    check("ign_latency", n, 8);
                    check("ign_result", 32'(bcd), 32'h153);
                end
            end
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check("ign_pulses", pulses, 1);
        check("ign_idle", 32'(busy), 0);
        check("ign_hold", 32'(bcd), 32'h153);

        // Back-to-back with start held high
        @(negedge clk);
        start = 1'b1; binary = 8'd42;
        @(posedge clk);
        @(negedge clk);
        binary = 8'd99;
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check("b2b_latency1", n, 8);
        check("b2b_result1", 32'(bcd), 32'h042);
        m = 0;
        do begin
            @(posedge clk);
            m++;
            @(negedge clk);
            if (m == 1) begin
                start = 1'b0;
                check("b2b_accept", 32'(busy), 1);
            end
        end while (!done && m < 30);
        check("b2b_spacing", m, 9);
        check("b2b_result2", 32'(bcd), 32'h099);
        prev_bcd = 12'h099;
        @(negedge clk);

        // Reset on the 4th SHIFT cycle aborts with no done pulse
        start = 1'b1; binary = 8'd255;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_bcd", 32'(bcd), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) pulses++;
            @(negedge clk);
        end
        check("abort_quiet", pulses, 0);
        prev_bcd = 12'h000;
        run_conv(8'd7, 12'h007);

        // WIDTH=10, DIGITS=4
        @(negedge clk);
        b_start = 1'b1; b_binary = 10'd1023;
        @(posedge clk);
        @(negedge clk);
        b_start = 1'b0;
        n = 0;
        while (!b_done && n < 30) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check("w10_latency", n, 10);
        check("w10_result", 32'(b_bcd), 32'h1023);

        // WIDTH=1, DIGITS=1
        @(negedge clk);
        c_start = 1'b1; c_binary = 1'b1;
        @(posedge clk);
        @(negedge clk);
        c_start = 1'b0;
        check("w1_busy", 32'(c_busy), 1);
        n = 0;
        while (!c_done && n < 10) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check("w1_latency", n, 1);
        check("w1_result", 32'(c_bcd), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
